ic_test_sequencer: RTL and testbench
====================================

Name: ic_test_sequencer

Overview:
- Top-level test controller for the IC tester. Owns the enables of the per-type gate checkers (NOT, AND, OR, NAND, NOR, XOR), which share the DUT socket.
- Manual mode: runs the checker for one operator-selected IC type and reports pass, fail or timeout.
- Auto mode: steps through every checker in index order and reports the first type that passes, which identifies an unknown IC.
- Exactly one checker is enabled at a time. Between checkers, every enable is held low so that each checker clears its flags.

Parameters:
- NUM_CHECKERS, 6, number of gate checkers (index 0 = NOT, then AND, OR, NAND, NOR, XOR).
- IDX_W, 3, width of the type index; must satisfy 2^IDX_W >= NUM_CHECKERS.
- SETTLE_CYCLES, 1000, cycles with all enables low before each checker run.
- TIMEOUT_CYCLES, 200000000, maximum run cycles per checker (4 s at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test; ignored while busy=1
- abort  in  1  level; returns the FSM to IDLE at the next edge
- auto_mode  in  1  sampled on start; 1 = scan all types, 0 = test ic_type only
- ic_type  in  IDX_W  sampled on start; manual-mode checker index
- chk_pass  in  NUM_CHECKERS  overall pass flag of each checker
- chk_fail  in  NUM_CHECKERS  overall fail flag of each checker
- chk_enable  out  NUM_CHECKERS  one-hot or zero checker enables
- busy  out  1  test in progress
- done  out  1  one-cycle pulse when a result is posted
- result_pass  out  1  sticky; last test passed
- result_fail  out  1  sticky; last test failed (manual fail, or auto with no match)
- result_timeout  out  1  sticky; manual run reached timeout without a verdict
- found_type  out  IDX_W  checker index that produced the pass

Behaviour:
- Reset, asynchronous:
  - Outputs: chk_enable=0, busy=0, done=0, result_*=0, found_type=0.
  - Internal: state=IDLE, counters=0.
- States: IDLE, SETTLE, RUN, NEXT, REPORT.
- IDLE:
  - On start, latch auto_mode and ic_type, then go to SETTLE.
  - Start index is 0 in auto mode and ic_type in manual mode.
  - Clear result_* and found_type on the same edge.
  - busy=1 from the cycle after start.
  - In manual mode, ic_type >= NUM_CHECKERS gives REPORT with result_fail=1, found_type=ic_type, and no enable is asserted.
- SETTLE:
  - chk_enable=0.
  - Count SETTLE_CYCLES cycles, then go to RUN with the counter cleared.
- RUN:
  - chk_enable = one-hot of the current index; the run counter increments each cycle.
  - If chk_pass[idx] is seen: found_type=idx, result_pass=1, go to REPORT.
  - Else if chk_fail[idx] is seen: manual mode gives result_fail=1 and REPORT; auto mode goes to NEXT.
  - Else if the counter equals TIMEOUT_CYCLES-1: manual mode gives result_timeout=1 and REPORT; auto mode goes to NEXT.
  - Pass and fail on the same cycle: pass wins.
  - Flags on non-selected checkers are ignored.
- NEXT:
  - chk_enable=0.
  - If idx == NUM_CHECKERS-1: result_fail=1, found_type=0, go to REPORT.
  - Otherwise idx+1, go to SETTLE.
  - The index never wraps.
- REPORT: chk_enable=0, done=1 for exactly one cycle, busy=0, go to IDLE.
- Result lifetime: result_* and found_type hold until the next accepted start, or reset.
- abort:
  - From any non-IDLE state: chk_enable=0, busy=0, go to IDLE at the next edge.
  - No done pulse; result_* stay 0.
  - abort has priority over start on the same cycle.
- Timing:
  - chk_enable changes only on state transitions and is registered; no glitching.
  - Minimum latency from start to the first enable is SETTLE_CYCLES+2 cycles.
- Counter widths: 32 bits, comparisons are equality, no overflow is reachable.

Decomposition:
- Package ic_tester_pkg holds:
  - The state enum.
  - Checker index localparams: IDX_NOT=0, IDX_AND=1, IDX_OR=2, IDX_NAND=3, IDX_NOR=4, IDX_XOR=5.
  - Default SETTLE and TIMEOUT constants.
- One sub-module, cycle_timer: loadable down-counter with a clear input and a terminal-count flag. It is used for both the settle period and the timeout.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=20):
- Manual pass: start, auto_mode=0, ic_type=3; chk_pass[3]=1 at run cycle 5 -> chk_enable=6'b001000 during RUN, then done pulse, result_pass=1, found_type=3.
- Manual timeout: ic_type=1 and no flags -> chk_enable=6'b000010 for exactly 20 cycles, then result_timeout=1, result_pass=0, done once.
- Auto identify: auto_mode=1; fail flags for idx 0 and 1, pass for idx 2 -> enable sequence 000001, 000010, 000100, each run separated by 4 zero-enable cycles; found_type=2, result_pass=1.
- Auto no match: all checkers time out -> 6 runs, result_fail=1, done once, chk_enable never has more than one bit set.
- Priority and ignoring:
  - chk_pass[0] and chk_fail[0] asserted on the same cycle -> result_pass=1.
  - chk_pass[5] asserted while idx=0 -> ignored.
  - start pulsed while busy -> ignored.
- Abort and reset:
  - abort during RUN -> IDLE next cycle, chk_enable=0, no done pulse.
  - rst_n low mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ic_tester_pkg.sv
// Shared types and constants for the IC tester: sequencer states, checker
// indices and default timing.
package ic_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RUN,
      ST_NEXT,
      ST_REPORT
   } seq_state_t;

   localparam int IDX_NOT  = 0;
   localparam int IDX_AND  = 1;
   localparam int IDX_OR   = 2;
   localparam int IDX_NAND = 3;
   localparam int IDX_NOR  = 4;
   localparam int IDX_XOR  = 5;

   localparam int CNT_W              = 32;
   localparam int DEF_SETTLE_CYCLES  = 1000;
   localparam int DEF_TIMEOUT_CYCLES = 200000000;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with synchronous clear; tc is high while the count
// sits at zero, so a load of N reaches tc N+1 cycles after the load edge.
module cycle_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/ic_test_sequencer.sv
// Test controller for the shared-socket gate checkers: runs one selected
// checker (manual) or scans all of them in order (auto) and posts the verdict.
module ic_test_sequencer
   import ic_tester_pkg::*;
#(
   parameter int NUM_CHECKERS   = 6,
   parameter int IDX_W          = 3,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    auto_mode,
   input  logic [IDX_W-1:0]        ic_type,
   input  logic [NUM_CHECKERS-1:0] chk_pass,
   input  logic [NUM_CHECKERS-1:0] chk_fail,
   output logic [NUM_CHECKERS-1:0] chk_enable,
   output logic                    busy,
   output logic                    done,
   output logic                    result_pass,
   output logic                    result_fail,
   output logic                    result_timeout,
   output logic [IDX_W-1:0]        found_type
);

   localparam logic [CNT_W-1:0]        SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]        TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0]          NUM_CHK      = (IDX_W + 1)'(NUM_CHECKERS);
   localparam logic [IDX_W-1:0]        LAST_IDX     = IDX_W'(NUM_CHECKERS - 1);
   localparam logic [IDX_W-1:0]        FIRST_IDX    = IDX_W'(IDX_NOT);
   localparam logic [NUM_CHECKERS-1:0] ONE_HOT0     = NUM_CHECKERS'(1);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             auto_q;

   logic             tmr_load;
   logic             tmr_clear;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_tc;

   logic             start_ok;
   logic             start_bad;
   logic             abort_act;
   logic             sel_pass;
   logic             sel_fail;

   assign abort_act = abort && (state != ST_IDLE);
   assign start_ok  = start && !abort;
   assign start_bad = !auto_mode && ({1'b0, ic_type} >= NUM_CHK);
   assign sel_pass  = chk_pass[idx];
   assign sel_fail  = chk_fail[idx];

   // The shared timer serves both the settle window and the run timeout
   always_comb begin
      tmr_load  = 1'b0;
      tmr_clear = 1'b0;
      tmr_val   = SETTLE_LOAD;
      if (abort_act) begin
         tmr_clear = 1'b1;
      end else begin
         case (state)
            ST_IDLE:   tmr_load = start_ok && !start_bad;
            ST_SETTLE: begin
               tmr_load = tmr_tc;
               tmr_val  = TIMEOUT_LOAD;
            end
            ST_RUN:    tmr_clear = sel_pass || sel_fail || tmr_tc;
            ST_NEXT:   tmr_load = (idx != LAST_IDX);
            default:   ;
         endcase
      end
   end

   cycle_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .clear    (tmr_clear),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         idx            <= '0;
         auto_q         <= 1'b0;
         chk_enable     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         result_pass    <= 1'b0;
         result_fail    <= 1'b0;
         result_timeout <= 1'b0;
         found_type     <= '0;
      end else if (abort_act) begin
         state      <= ST_IDLE;
         chk_enable <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start_ok) begin
                  auto_q         <= auto_mode;
                  result_pass    <= 1'b0;
                  result_fail    <= 1'b0;
                  result_timeout <= 1'b0;
                  found_type     <= '0;
                  if (start_bad) begin
                     result_fail <= 1'b1;
                     found_type  <= ic_type;
                     done        <= 1'b1;
                     state       <= ST_REPORT;
                  end else begin
                     idx   <= auto_mode ? FIRST_IDX : ic_type;
                     busy  <= 1'b1;
                     state <= ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               if (tmr_tc) begin
                  chk_enable <= ONE_HOT0 << idx;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Pass outranks fail and timeout; a failing scan step moves on
               if (sel_pass || (!auto_q && (sel_fail || tmr_tc))) begin
                  chk_enable <= '0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= ST_REPORT;
                  if (sel_pass) begin
                     result_pass <= 1'b1;
                     found_type  <= idx;
                  end else if (sel_fail) begin
                     result_fail <= 1'b1;
                  end else begin
                     result_timeout <= 1'b1;
                  end
               end else if (sel_fail || tmr_tc) begin
                  chk_enable <= '0;
                  state      <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (idx == LAST_IDX) begin
                  result_fail <= 1'b1;
                  found_type  <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= ST_REPORT;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= ST_SETTLE;
               end
            end
            ST_REPORT: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               chk_enable <= '0;
               busy       <= 1'b0;
               done       <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed bench for ic_test_sequencer with a short settle window and timeout.
module tb_ic_test_sequencer;
   import ic_tester_pkg::*;

   localparam int NC = 6;
   localparam int IW = 3;
   localparam int S  = 4;
   localparam int T  = 20;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          auto_mode;
   logic [IW-1:0] ic_type;
   logic [NC-1:0] chk_pass;
   logic [NC-1:0] chk_fail;
   logic [NC-1:0] chk_enable;
   logic          busy;
   logic          done;
   logic          result_pass;
   logic          result_fail;
   logic          result_timeout;
   logic [IW-1:0] found_type;

   int n_vec = 0;
   int n_err = 0;

   int            done_total  = 0;
   int            multi_total = 0;
   int            en_hi_total = 0;
   int            zero_run    = 0;
   logic [NC-1:0] prev_en     = '0;
   logic [NC-1:0] en_seq[$];
   int            gap_seq[$];

   ic_test_sequencer #(
      .NUM_CHECKERS   (NC),
      .IDX_W          (IW),
      .SETTLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .auto_mode      (auto_mode),
      .ic_type        (ic_type),
      .chk_pass       (chk_pass),
      .chk_fail       (chk_fail),
      .chk_enable     (chk_enable),
      .busy           (busy),
      .done           (done),
      .result_pass    (result_pass),
      .result_fail    (result_fail),
      .result_timeout (result_timeout),
      .found_type     (found_type)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-cycle observer of enables and done pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (done) done_total++;
      if ($countones(chk_enable) > 1) multi_total++;
      if (chk_enable != '0) begin
         en_hi_total++;
         if (prev_en == '0) begin
            en_seq.push_back(chk_enable);
            gap_seq.push_back(zero_run);
         end
         zero_run = 0;
      end else begin
         zero_run++;
      end
      prev_en = chk_enable;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic am, input logic [IW-1:0] ty);
      auto_mode = am;
      ic_type   = ty;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
   endtask

   task automatic wait_en(input int max, output int n);
      n = 0;
      while (chk_enable == '0 && n < max) begin
         tick(1);
         n++;
      end
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!done && n < max) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      int n;
      int d0;
      int h0;
      int q0;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; auto_mode = 1'b0;
      ic_type = '0; chk_pass = '0; chk_fail = '0;
      tick(3);
      check("rst_en", 32'(chk_enable), 32'd0);
      check("rst_flags", 32'({busy, done, result_pass, result_fail, result_timeout}), 32'd0);
      check("rst_found", 32'(found_type), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Manual pass on NAND at run cycle 5
      pulse_start(1'b0, IW'(IDX_NAND));
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_en_settle", 32'(chk_enable), 32'd0);
      wait_en(50, n);
      check("t1_latency", 32'(n + 1), 32'(S + 2));
      check("t1_en", 32'(chk_enable), 32'b001000);
      tick(4);
      chk_pass = 6'b001000;
      tick(1);
      chk_pass = '0;
      check("t1_done", 32'(done), 32'd1);
      check("t1_pass", 32'(result_pass), 32'd1);
      check("t1_found", 32'(found_type), 32'd3);
      check("t1_busy_off", 32'(busy), 32'd0);
      check("t1_en_off", 32'(chk_enable), 32'd0);
      tick(1);
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_pass_sticky", 32'(result_pass), 32'd1);

      // Manual timeout on AND
      d0 = done_total; h0 = en_hi_total; q0 = en_seq.size();
      pulse_start(1'b0, IW'(IDX_AND));
      check("t2_pass_clr", 32'(result_pass), 32'd0);
      wait_done(100, n);
      check("t2_done", 32'(done), 32'd1);
      check("t2_timeout", 32'(result_timeout), 32'd1);
      check("t2_pass", 32'(result_pass), 32'd0);
      check("t2_fail", 32'(result_fail), 32'd0);
      check("t2_en_cycles", 32'(en_hi_total - h0), 32'(T));
      check("t2_runs", 32'(en_seq.size() - q0), 32'd1);
      check("t2_en_val", 32'(en_seq[q0]), 32'b000010);
      tick(2);
      check("t2_done_once", 32'(done_total - d0), 32'd1);

      // Auto identify: NOT and AND fail, OR passes
      chk_fail = 6'b000011; chk_pass = 6'b000100;
      d0 = done_total; q0 = en_seq.size();
      pulse_start(1'b1, IW'(IDX_XOR));
      wait_done(200, n);
      chk_fail = '0; chk_pass = '0;
      check("t3_done", 32'(done), 32'd1);
      check("t3_pass", 32'(result_pass), 32'd1);
      check("t3_fail", 32'(result_fail), 32'd0);
      check("t3_found", 32'(found_type), 32'd2);
      check("t3_runs", 32'(en_seq.size() - q0), 32'd3);
      check("t3_en0", 32'(en_seq[q0]), 32'b000001);
      check("t3_en1", 32'(en_seq[q0 + 1]), 32'b000010);
      check("t3_en2", 32'(en_seq[q0 + 2]), 32'b000100);
      check("t3_gap1", 32'(gap_seq[q0 + 1] >= S), 32'd1);
      check("t3_gap2", 32'(gap_seq[q0 + 2] >= S), 32'd1);
      tick(2);
      check("t3_done_once", 32'(done_total - d0), 32'd1);

      // Auto scan with no match: every checker times out
      d0 = done_total; q0 = en_seq.size(); h0 = multi_total;
      pulse_start(1'b1, '0);
      wait_done(400, n);
      check("t4_done", 32'(done), 32'd1);
      check("t4_fail", 32'(result_fail), 32'd1);
      check("t4_pass", 32'(result_pass), 32'd0);
      check("t4_timeout", 32'(result_timeout), 32'd0);
      check("t4_found", 32'(found_type), 32'd0);
      check("t4_runs", 32'(en_seq.size() - q0), 32'd6);
      for (int i = 0; i < NC; i++) begin
         check($sformatf("t4_en%0d", i), 32'(en_seq[q0 + i]), 32'(1 << i));
      end
      tick(2);
      check("t4_done_once", 32'(done_total - d0), 32'd1);
      check("t4_onehot", 32'(multi_total - h0), 32'd0);

      // Pass and fail together on the selected checker
      chk_pass = 6'b000001; chk_fail = 6'b000001;
      pulse_start(1'b0, IW'(IDX_NOT));
      wait_done(100, n);
      chk_pass = '0; chk_fail = '0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_pass", 32'(result_pass), 32'd1);
      check("t5_fail", 32'(result_fail), 32'd0);
      tick(1);

      // Foreign pass flag and start-while-busy are both ignored
      chk_pass = 6'b100000;
      pulse_start(1'b0, IW'(IDX_NOT));
      wait_en(50, n);
      check("t6_en", 32'(chk_enable), 32'b000001);
      tick(2);
      check("t6_ignore_foreign", 32'({busy, done}), 32'b10);
      pulse_start(1'b1, IW'(IDX_NOR));
      check("t6_restart_ignored", 32'(chk_enable), 32'b000001);
      check("t6_busy", 32'(busy), 32'd1);
      wait_done(100, n);
      chk_pass = '0;
      check("t6_timeout", 32'(result_timeout), 32'd1);
      check("t6_pass", 32'(result_pass), 32'd0);
      tick(1);

      // Abort during RUN
      pulse_start(1'b0, IW'(IDX_OR));
      wait_en(50, n);
      check("t7_en", 32'(chk_enable), 32'b000100);
      tick(2);
      d0 = done_total;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_en_off", 32'(chk_enable), 32'd0);
      check("t7_results", 32'({done, result_pass, result_fail, result_timeout}), 32'd0);
      tick(S + 10);
      check("t7_no_done", 32'(done_total - d0), 32'd0);
      check("t7_idle_en", 32'(chk_enable), 32'd0);

      // Out-of-range manual type reports a failure without enabling anything
      pulse_start(1'b0, 3'd7);
      check("t8_done", 32'(done), 32'd1);
      check("t8_fail", 32'(result_fail), 32'd1);
      check("t8_found", 32'(found_type), 32'd7);
      check("t8_en", 32'(chk_enable), 32'd0);
      check("t8_busy", 32'(busy), 32'd0);
      tick(1);

      // Abort outranks start in IDLE, so the previous result survives
      abort = 1'b1;
      pulse_start(1'b0, IW'(IDX_AND));
      abort = 1'b0;
      check("t9_busy", 32'(busy), 32'd0);
      check("t9_held", 32'(result_fail), 32'd1);
      tick(2);

      // Asynchronous reset in the middle of SETTLE
      pulse_start(1'b1, '0);
      tick(2);
      check("t10_busy_pre", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t10_async", 32'({busy, done, result_pass, result_fail, result_timeout}), 32'd0);
      check("t10_en", 32'(chk_enable), 32'd0);
      #2 rst_n = 1'b1;
      tick(2);
      check("all_onehot", 32'(multi_total), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
